// File: rtl/kmap_pkg.sv
// Shared definitions for the Karnaugh-code frame checker: FSM states, widths
// and the reference {x,y,z} code function used by the encoder and checker.
package kmap_pkg;

    localparam int CODE_W = 3;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_e;

    function automatic logic [CODE_W-1:0] kmap_code(input logic [NIB_W-1:0] nibble);
        logic a, b, c, d;
        logic x, y, z;
        {d, c, b, a} = nibble;
        x = (~d & b & ~a) | (~c & ~a) | (d & ~b) | (c & b & a);
        y = (a & ~b & ~d) | (~a & ~b & d) | (a & b & d) | (~a & b);
        z = b ^ c ^ d;
        return {x, y, z};
    endfunction

endpackage

// File: rtl/kmap_frame_checker_if.sv
// Word stream into the checker: source nibble plus received code, valid/ready.
interface kmap_frame_checker_if;
    import kmap_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [NIB_W-1:0]  in_nibble;
    logic [CODE_W-1:0] in_code;

    modport master (output in_valid, output in_nibble, output in_code, input in_ready);
    modport slave  (input in_valid, input in_nibble, input in_code, output in_ready);

endinterface

// File: rtl/kmap_code_gen.sv
// Combinational local recomputation of the 3-bit Karnaugh code from a nibble.
module kmap_code_gen
    import kmap_pkg::*;
(
    input  logic [NIB_W-1:0]  nibble,
    output logic [CODE_W-1:0] code
);

    assign code = kmap_code(nibble);

endmodule

// File: rtl/kmap_frame_checker.sv
// Frame checker: accepts FRAME_LEN words, recomputes each code in a two-stage
// pipeline, counts mismatches and reports per-frame pass/fail.
module kmap_frame_checker
    import kmap_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    kmap_frame_checker_if.slave in_if,
    output logic              busy,
    output logic              done,
    output logic              frame_ok,
    output logic [CNT_W-1:0]  err_count,
    output logic [CODE_W-1:0] err_bits
);

    localparam int WC_W = 8;
    typedef logic [WC_W-1:0] wc_t;
    localparam wc_t LAST_WORD = wc_t'(FRAME_LEN - 1);

    state_e            state_q, state_d;
    wc_t               word_cnt_q, word_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic [NIB_W-1:0]  s1_nibble_q, s1_nibble_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CODE_W-1:0] err_bits_q, err_bits_d;
    logic              frame_ok_q, frame_ok_d;

    logic              xfer;
    logic              last_xfer;
    logic              mismatch;
    logic [CODE_W-1:0] local_code;
    logic [CODE_W-1:0] code_diff;

    kmap_code_gen u_code_gen (
        .nibble (s1_nibble_q),
        .code   (local_code)
    );

    for (genvar gi = 0; gi < CODE_W; gi++) begin : g_diff
        assign code_diff[gi] = local_code[gi] ^ s1_code_q[gi];
    end

    assign mismatch  = |code_diff;
    assign xfer      = in_if.in_valid && (state_q == RUN);
    assign last_xfer = xfer && (word_cnt_q == LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_xfer) state_d = DRAIN;
            DRAIN:   state_d = REPORT;
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_if.in_ready = (state_q == RUN);
        busy           = (state_q != IDLE);
        done           = (state_q == REPORT);
    end

    // Stage 1 captures each accepted word; stage 2 folds its comparison into
    // the frame statistics one cycle later.
    always_comb begin
        s1_valid_d  = xfer;
        s1_nibble_d = xfer ? in_if.in_nibble : s1_nibble_q;
        s1_code_d   = xfer ? in_if.in_code   : s1_code_q;
        word_cnt_d  = word_cnt_q;
        err_count_d = err_count_q;
        err_bits_d  = err_bits_q;
        frame_ok_d  = frame_ok_q;

        if ((state_q == IDLE) && start) begin
            word_cnt_d  = '0;
            err_count_d = '0;
            err_bits_d  = '0;
        end else begin
            if (xfer) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
            if (s1_valid_q && mismatch) begin
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + 1'b1;
                end
                err_bits_d = err_bits_q | code_diff;
            end
        end

        if (state_q == REPORT) begin
            frame_ok_d = (err_count_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_nibble_q <= '0;
            s1_code_q   <= '0;
            err_count_q <= '0;
            err_bits_q  <= '0;
            frame_ok_q  <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_nibble_q <= s1_nibble_d;
            s1_code_q   <= s1_code_d;
            err_count_q <= err_count_d;
            err_bits_q  <= err_bits_d;
            frame_ok_q  <= frame_ok_d;
        end
    end

    assign err_count = err_count_q;
    assign err_bits  = err_bits_q;
    assign frame_ok  = frame_ok_q;

endmodule

// File: tb/tb_kmap_frame_checker.sv
// Scoreboard bench for kmap_frame_checker: a main 8-word instance and a
// narrow-counter instance for saturation.
module tb_kmap_frame_checker;
    import kmap_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start, busy, done, frame_ok;
    logic [7:0] err_count;
    logic [2:0] err_bits;
    kmap_frame_checker_if m_if ();

    kmap_frame_checker #(.FRAME_LEN(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_if     (m_if),
        .busy      (busy),
        .done      (done),
        .frame_ok  (frame_ok),
        .err_count (err_count),
        .err_bits  (err_bits)
    );

    logic       s_start, s_busy, s_done, s_frame_ok;
    logic [1:0] s_err_count;
    logic [2:0] s_err_bits;
    kmap_frame_checker_if s_if ();

    kmap_frame_checker #(.FRAME_LEN(6), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s_start),
        .in_if     (s_if),
        .busy      (s_busy),
        .done      (s_done),
        .frame_ok  (s_frame_ok),
        .err_count (s_err_count),
        .err_bits  (s_err_bits)
    );

    // Expected code per nibble {d,c,b,a}, worked out by hand from the K-map equations.
    logic [2:0] ref_code [16];

    typedef struct { int due; int cnt; logic [2:0] bits; } word_exp_t;
    typedef struct { int due; int cnt; logic [2:0] bits; logic ok; } frame_exp_t;
    word_exp_t  wq[$];
    frame_exp_t fq[$];
    int         okq_due[$];
    logic       okq_val[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         model_cnt;
    logic [2:0] model_bits;
    logic [3:0] w_nib  [8];
    logic [2:0] w_code [8];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output side of the scoreboard: per-word statistics at t+2, done at t+2, frame_ok at t+3.
    always @(negedge clk) begin : chk_proc
        word_exp_t  e;
        frame_exp_t f;
        if (rst_n) begin
            if (wq.size() > 0 && wq[0].due == cyc) begin
                e = wq.pop_front();
                check_eq("word_err_count", err_count, e.cnt);
                check_eq("word_err_bits", err_bits, e.bits);
            end
            if (fq.size() > 0 && fq[0].due == cyc) begin
                f = fq.pop_front();
                check_eq("done_pulse", done, 1);
                check_eq("done_err_count", err_count, f.cnt);
                check_eq("done_err_bits", err_bits, f.bits);
                okq_due.push_back(cyc + 1);
                okq_val.push_back(f.ok);
                $display("frame done at cycle %0d: err_count=%0d err_bits=%b", cyc, err_count, err_bits);
            end else if (done) begin
                check_eq("done_unexpected", done, 0);
            end
            if (okq_due.size() > 0 && okq_due[0] == cyc) begin
                check_eq("frame_ok", frame_ok, okq_val[0]);
                void'(okq_due.pop_front());
                void'(okq_val.pop_front());
            end
        end
    end

    task automatic go_start();
        int k;
        start = 1'b1;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy) check_eq("start_timeout", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        model_cnt  = 0;
        model_bits = 3'b000;
        check_eq("ready_after_start", m_if.in_ready, 1);
        check_eq("clr_err_count", err_count, 0);
        check_eq("clr_err_bits", err_bits, 0);
    endtask

    // Input side: drive n words, record each transfer's expectations.
    task automatic send_frame(input int n, input bit gaps);
        int         i, k;
        logic [2:0] diff;
        i = 0;
        while (i < n) begin
            m_if.in_nibble = w_nib[i];
            m_if.in_code   = w_code[i];
            if (gaps && $urandom_range(0, 2) == 0) begin
                m_if.in_valid = 1'b0;
                start = ($urandom_range(0, 1) == 1);
                @(posedge clk); #1;
                start = 1'b0;
                continue;
            end
            m_if.in_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!m_if.in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!m_if.in_ready) begin
                check_eq("ready_timeout", m_if.in_ready, 1);
                break;
            end
            diff = ref_code[w_nib[i]] ^ w_code[i];
            if (diff != 3'b000) begin
                if (model_cnt < 255) model_cnt++;
                model_bits = model_bits | diff;
            end
            wq.push_back('{due: cyc + 2, cnt: model_cnt, bits: model_bits});
            if (i == 7 && n == 8)
                fq.push_back('{due: cyc + 2, cnt: model_cnt, bits: model_bits, ok: (model_cnt == 0)});
            $display("xfer cycle %0d word %0d nib=%h code=%b exp_cnt=%0d", cyc, i, w_nib[i], w_code[i], model_cnt);
            i++;
            @(posedge clk); #1;
        end
        m_if.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((fq.size() > 0 || okq_due.size() > 0 || wq.size() > 0) && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (fq.size() > 0 || okq_due.size() > 0 || wq.size() > 0) begin
            check_eq("done_timeout", fq.size() + okq_due.size() + wq.size(), 0);
            wq.delete(); fq.delete(); okq_due.delete(); okq_val.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_in_ready"}, m_if.in_ready, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_frame_ok"}, frame_ok, 0);
        check_eq({tag, "_err_count"}, err_count, 0);
        check_eq({tag, "_err_bits"}, err_bits, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k, sat_cnt;
        logic [2:0] sat_bits;
        ref_code = '{3'd4, 3'd2, 3'd7, 3'd1, 3'd1, 3'd3, 3'd6, 3'd4,
                     3'd7, 3'd5, 3'd6, 3'd2, 3'd6, 3'd4, 3'd3, 3'd7};
        rst_n = 1'b0;
        start = 1'b0;
        s_start = 1'b0;
        m_if.in_valid = 1'b0; m_if.in_nibble = '0; m_if.in_code = '0;
        s_if.in_valid = 1'b0; s_if.in_nibble = '0; s_if.in_code = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame.
        for (int i = 0; i < 8; i++) begin
            w_nib[i]  = (i % 2 == 0) ? 4'h0 : 4'hF;
            w_code[i] = (i % 2 == 0) ? 3'b100 : 3'b111;
        end
        go_start();
        send_frame(8, 1'b0);
        wait_idle();

        // Reset after 3 of 8 transfers.
        go_start();
        send_frame(3, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        wq.delete(); fq.delete(); okq_due.delete(); okq_val.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("idle_in_ready", m_if.in_ready, 0);
            check_eq("idle_done", done, 0);
        end

        // Single-bit error in word 4.
        for (int i = 0; i < 8; i++) begin
            w_nib[i]  = 4'h5;
            w_code[i] = (i == 4) ? 3'b001 : 3'b011;
        end
        go_start();
        send_frame(8, 1'b0);
        wait_idle();

        // Random stalls, random errors, stray start pulses during RUN.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                w_nib[i]  = 4'($urandom_range(0, 15));
                w_code[i] = ref_code[w_nib[i]];
                if ($urandom_range(0, 3) == 0)
                    w_code[i] = w_code[i] ^ 3'(1 << $urandom_range(0, 2));
            end
            go_start();
            send_frame(8, 1'b1);
            wait_idle();
        end

        // Back-to-back: erroneous frame, then a clean one started without a gap.
        for (int i = 0; i < 8; i++) begin
            w_nib[i]  = 4'(i * 2);
            w_code[i] = ~ref_code[4'(i * 2)];
        end
        go_start();
        send_frame(8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w_nib[i]  = 4'(i + 8);
            w_code[i] = ref_code[4'(i + 8)];
        end
        go_start();
        send_frame(8, 1'b0);
        wait_idle();

        // Saturation on the 2-bit counter instance.
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        sat_cnt  = 0;
        sat_bits = 3'b000;
        for (int i = 0; i < 6; i++) begin
            s_if.in_nibble = 4'(i);
            s_if.in_code   = ~ref_code[i];
            s_if.in_valid  = 1'b1;
            @(negedge clk);
            check_eq("sat_in_ready", s_if.in_ready, 1);
            if (sat_cnt < 3) sat_cnt++;
            sat_bits = sat_bits | (ref_code[i] ^ ~ref_code[i]);
            $display("sat xfer cycle %0d word %0d exp_cnt=%0d", cyc, i, sat_cnt);
            @(posedge clk); #1;
        end
        s_if.in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!s_done && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("sat_done", s_done, 1);
        check_eq("sat_err_count", s_err_count, sat_cnt);
        check_eq("sat_err_bits", s_err_bits, sat_bits);
        @(negedge clk);
        check_eq("sat_frame_ok", s_frame_ok, 0);
        check_eq("sat_hold_count", s_err_count, sat_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
